// File: rtl/swerv_types.sv
// ============================================================================
// Module : swerv_types
// Shared size encodings, arbiter state and DC1 packet types for the LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package swerv_types;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_DBL  = 2'd3;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BEAT2 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic        dma;
        logic        store;
        logic        by;
        logic        half;
        logic        word;
        logic [31:0] addr;
        logic        last;
    } lsu_pkt_t;

endpackage

`default_nettype wire

// File: rtl/lsu_arb_endaddr.sv
// ============================================================================
// Module : lsu_arb_endaddr
// Decodes access size to one-hot and computes the inclusive end byte address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_arb_endaddr
    import swerv_types::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] start_addr,
    output logic        by,
    output logic        half,
    output logic        word,
    output logic [31:0] end_addr
);

    always_comb begin
        by   = (size == SZ_BYTE);
        half = (size == SZ_HALF);
        // Word and double (already split into word beats) both span 4 bytes.
        word = ~by & ~half;
        end_addr = start_addr + (word ? 32'd3 : (half ? 32'd1 : 32'd0));
    end

endmodule

`default_nettype wire

// File: rtl/lsu_dccm_arb.sv
// ============================================================================
// Module : lsu_dccm_arb
// Core/DMA arbiter for the DC1 access slot with double-word beat splitting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dccm_arb
    import swerv_types::*;
#(
    parameter int DMA_STARVE_MAX = 15,
    parameter int CNT_W          = $clog2(DMA_STARVE_MAX + 1)
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        stall_dc1,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic [31:0] core_addr,
    input  logic [1:0]  core_size,
    input  logic        core_store,
    input  logic [31:0] core_wdata,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic [31:0] dma_addr,
    input  logic [1:0]  dma_size,
    input  logic        dma_store,
    input  logic [63:0] dma_wdata,
    output logic        valid_dc1,
    output logic        dma_dc1,
    output logic        store_dc1,
    output logic        by_dc1,
    output logic        half_dc1,
    output logic        word_dc1,
    output logic [31:0] start_addr_dc1,
    output logic [31:0] end_addr_dc1,
    output logic [31:0] wdata_dc1,
    output logic        dma_last_dc1,
    output logic        dma_forced
);

    arb_state_e     state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic           active, beat2, grant_dma, grant_core, grant;
    logic [1:0]     mux_size;
    logic [31:0]    mux_addr, mux_wdata, mux_end;
    logic           mux_by, mux_half, mux_word;
    lsu_pkt_t       pkt_d, pkt_q;
    logic [31:0]    end_q, wdata_q;

    assign active     = rst_l & ~stall_dc1;
    assign beat2      = (state == ARB_BEAT2);
    assign dma_forced = (starve_cnt == CNT_W'(DMA_STARVE_MAX));

    always_comb begin
        grant_dma  = active & (beat2 | (dma_req_valid & (dma_forced | ~core_req_valid)));
        grant_core = active & ~beat2 & ~grant_dma & core_req_valid;
        grant      = grant_dma | grant_core;
    end

    assign core_req_ready = grant_core;
    assign dma_req_ready  = grant_dma & ((dma_size != SZ_DBL) | beat2);

    always_comb begin
        if (grant_dma) begin
            mux_addr  = beat2 ? (dma_addr + 32'd4) : dma_addr;
            mux_size  = (dma_size == SZ_DBL) ? SZ_WORD : dma_size;
            mux_wdata = beat2 ? dma_wdata[63:32] : dma_wdata[31:0];
        end else begin
            mux_addr  = core_addr;
            mux_size  = (core_size == SZ_DBL) ? SZ_WORD : core_size;
            mux_wdata = core_wdata;
        end
    end

    lsu_arb_endaddr u_endaddr (
        .size       (mux_size),
        .start_addr (mux_addr),
        .by         (mux_by),
        .half       (mux_half),
        .word       (mux_word),
        .end_addr   (mux_end)
    );

    always_comb begin
        pkt_d.valid = 1'b1;
        pkt_d.dma   = grant_dma;
        pkt_d.store = grant_dma ? dma_store : core_store;
        pkt_d.by    = mux_by;
        pkt_d.half  = mux_half;
        pkt_d.word  = mux_word;
        pkt_d.addr  = mux_addr;
        pkt_d.last  = grant_dma & ((dma_size != SZ_DBL) | beat2);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pkt_q   <= '0;
            end_q   <= '0;
            wdata_q <= '0;
        end else if (!stall_dc1) begin
            if (grant) begin
                pkt_q   <= pkt_d;
                end_q   <= mux_end;
                wdata_q <= mux_wdata;
            end else begin
                pkt_q.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (grant_dma) begin
            if (beat2)
                state_nxt = ARB_IDLE;
            else if (dma_size == SZ_DBL)
                state_nxt = ARB_BEAT2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Waiting cycles accrue even while stalled; any DMA grant or withdrawal resets.
    always_ff @(posedge clk) begin
        if (!rst_l || grant_dma || !dma_req_valid)
            starve_cnt <= '0;
        else if (!dma_forced)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    assign valid_dc1      = pkt_q.valid;
    assign dma_dc1        = pkt_q.dma;
    assign store_dc1      = pkt_q.store;
    assign by_dc1         = pkt_q.by;
    assign half_dc1       = pkt_q.half;
    assign word_dc1       = pkt_q.word;
    assign start_addr_dc1 = pkt_q.addr;
    assign end_addr_dc1   = end_q;
    assign wdata_dc1      = wdata_q;
    assign dma_last_dc1   = pkt_q.last;

endmodule

`default_nettype wire
